// File: rtl/hazard_unit_if.sv
// Hazard unit bus: groups the IF/WB/flush inputs and the ID/stall/pending outputs.
// The master modport is the pipeline side; the slave modport is the hazard unit.
//   if_*    : IF-stage instruction (valid, sources ra/rb, destination rd, rd write, load)
//   wb_*    : returning load data (valid, destination register)
//   flush   : pipeline flush request
//   id_*    : ID-stage destination register and its valid flag
//   stall   : hold IF and bubble ID (combinational)
//   pending : pending-load bitmap, bit n = register xn
//   state   : FSM state, 0 = RUN, 1 = STALL
interface hazard_unit_if;
  logic        hzd_if_valid_in;
  logic [4:0]  hzd_if_ra_addr_in;
  logic [4:0]  hzd_if_rb_addr_in;
  logic [4:0]  hzd_if_rd_addr_in;
  logic        hzd_if_rd_we_in;
  logic        hzd_if_load_in;
  logic        hzd_wb_valid_in;
  logic [4:0]  hzd_wb_rd_addr_in;
  logic        hzd_flush_in;
  logic [4:0]  hzd_id_rd_addr_out;
  logic        hzd_id_rd_we_out;
  logic        hzd_stall_out;
  logic [31:0] hzd_pending_out;
  logic        hzd_state_out;

  modport master (
    output hzd_if_valid_in, hzd_if_ra_addr_in, hzd_if_rb_addr_in, hzd_if_rd_addr_in,
           hzd_if_rd_we_in, hzd_if_load_in, hzd_wb_valid_in, hzd_wb_rd_addr_in, hzd_flush_in,
    input  hzd_id_rd_addr_out, hzd_id_rd_we_out, hzd_stall_out, hzd_pending_out, hzd_state_out
  );

  modport slave (
    input  hzd_if_valid_in, hzd_if_ra_addr_in, hzd_if_rb_addr_in, hzd_if_rd_addr_in,
           hzd_if_rd_we_in, hzd_if_load_in, hzd_wb_valid_in, hzd_wb_rd_addr_in, hzd_flush_in,
    output hzd_id_rd_addr_out, hzd_id_rd_we_out, hzd_stall_out, hzd_pending_out, hzd_state_out
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard unit. Tracks registers with loads in flight, stalls an IF instruction
// that reads one of them, and drives the ID-stage destination register (bubble on stall,
// flush or non-writing instruction).
// Ports:
//   clock_in  : clock, rising edge
//   reset_in  : asynchronous active-low reset
//   hzd       : hazard_unit_if.slave bus (see rtl/hazard_unit_if.sv)
//   hzd_stall_count_out : saturating count of stalled cycles (only with HZD_STALL_COUNTER_EN)
// Optional feature macro: HZD_STALL_COUNTER_EN.
module hazard_unit (
  input logic          clock_in,
  input logic          reset_in,
  hazard_unit_if.slave hzd
`ifdef HZD_STALL_COUNTER_EN
  ,
  output logic [15:0]  hzd_stall_count_out
`endif
);

  typedef enum logic [0:0] {StRun = 1'b0, StStall = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  id_rd_q, id_rd_d;
  logic        id_we_q, id_we_d;
  logic        ra_hit, rb_hit, stall, accept;

  // A load returning this very cycle resolves the dependency, so it does not stall.
  always_comb begin
    ra_hit = (hzd.hzd_if_ra_addr_in != 5'd0) && pending_q[hzd.hzd_if_ra_addr_in] &&
             !(hzd.hzd_wb_valid_in && (hzd.hzd_wb_rd_addr_in == hzd.hzd_if_ra_addr_in));
    rb_hit = (hzd.hzd_if_rb_addr_in != 5'd0) && pending_q[hzd.hzd_if_rb_addr_in] &&
             !(hzd.hzd_wb_valid_in && (hzd.hzd_wb_rd_addr_in == hzd.hzd_if_rb_addr_in));
    stall  = hzd.hzd_if_valid_in && !hzd.hzd_flush_in && (ra_hit || rb_hit);
    accept = hzd.hzd_if_valid_in && !stall && !hzd.hzd_flush_in;
  end

  always_comb begin
    id_rd_d = 5'd0;
    id_we_d = 1'b0;
    if (accept && hzd.hzd_if_rd_we_in && (hzd.hzd_if_rd_addr_in != 5'd0)) begin
      id_rd_d = hzd.hzd_if_rd_addr_in;
      id_we_d = 1'b1;
    end

    // Clear first so a newer load to the same register wins.
    pending_d = pending_q;
    if (hzd.hzd_wb_valid_in) begin
      pending_d[hzd.hzd_wb_rd_addr_in] = 1'b0;
    end
    if (accept && hzd.hzd_if_load_in && hzd.hzd_if_rd_we_in &&
        (hzd.hzd_if_rd_addr_in != 5'd0)) begin
      pending_d[hzd.hzd_if_rd_addr_in] = 1'b1;
    end
    pending_d[0] = 1'b0;

    // stall already excludes flush, so flush always lands in StRun.
    state_d = stall ? StStall : StRun;
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= StRun;
      pending_q <= 32'd0;
      id_rd_q   <= 5'd0;
      id_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      id_rd_q   <= id_rd_d;
      id_we_q   <= id_we_d;
    end
  end

  assign hzd.hzd_id_rd_addr_out = id_rd_q;
  assign hzd.hzd_id_rd_we_out   = id_we_q;
  assign hzd.hzd_stall_out      = stall;
  assign hzd.hzd_pending_out    = pending_q;
  assign hzd.hzd_state_out      = (state_q == StStall);

`ifdef HZD_STALL_COUNTER_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      stall_cnt_q <= 16'd0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign hzd_stall_count_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: load-use stalls, same-cycle writeback bypass,
// x0 handling, set-over-clear, flush, reset mid-stall and the optional stall counter.
module tb_hazard_unit;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  hazard_unit_if hzd_bus ();

`ifdef HZD_STALL_COUNTER_EN
  logic [15:0] stall_count;
`endif

  hazard_unit dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .hzd      (hzd_bus)
`ifdef HZD_STALL_COUNTER_EN
    ,
    .hzd_stall_count_out (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rd, input logic we, input logic load,
                       input logic wbv, input logic [4:0] wbrd, input logic flush);
    hzd_bus.hzd_if_valid_in   = valid;
    hzd_bus.hzd_if_ra_addr_in = ra;
    hzd_bus.hzd_if_rb_addr_in = rb;
    hzd_bus.hzd_if_rd_addr_in = rd;
    hzd_bus.hzd_if_rd_we_in   = we;
    hzd_bus.hzd_if_load_in    = load;
    hzd_bus.hzd_wb_valid_in   = wbv;
    hzd_bus.hzd_wb_rd_addr_in = wbrd;
    hzd_bus.hzd_flush_in      = flush;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [4:0] rd, input logic we);
    check_eq({tag, "_id_rd"}, {27'd0, hzd_bus.hzd_id_rd_addr_out}, {27'd0, rd});
    check_eq({tag, "_id_we"}, {31'd0, hzd_bus.hzd_id_rd_we_out}, {31'd0, we});
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    check_id("reset", 5'd0, 1'b0);
    check_eq("reset_pending", hzd_bus.hzd_pending_out, 32'd0);
    check_eq("reset_state", {31'd0, hzd_bus.hzd_state_out}, 32'd0);
    check_eq("reset_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Load x5 accepted, then a reader of x5 stalls.
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("ld5_nostall", {31'd0, hzd_bus.hzd_stall_out}, 32'd0);
    tick();
    check_eq("ld5_pending", hzd_bus.hzd_pending_out, 32'h20);
    check_id("ld5", 5'd5, 1'b1);
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("use5_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd1);
    tick();
    check_id("use5_bubble", 5'd0, 1'b0);
    check_eq("use5_state", {31'd0, hzd_bus.hzd_state_out}, 32'd1);
    check_eq("use5_pending", hzd_bus.hzd_pending_out, 32'h20);

    // Writeback of x5 in the same cycle releases the stall.
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    check_eq("wb5_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd0);
    tick();
    check_eq("wb5_pending", hzd_bus.hzd_pending_out, 32'd0);
    check_id("wb5", 5'd6, 1'b1);
    check_eq("wb5_state", {31'd0, hzd_bus.hzd_state_out}, 32'd0);

    // Load x9, reader on rb stalls, then flush.
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    check_eq("ld9_pending", hzd_bus.hzd_pending_out, 32'h200);
    drive(1'b1, 5'd0, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("rb9_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd1);
    tick();
    check_eq("rb9_state", {31'd0, hzd_bus.hzd_state_out}, 32'd1);
    drive(1'b1, 5'd0, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    check_eq("flush_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd0);
    tick();
    check_eq("flush_state", {31'd0, hzd_bus.hzd_state_out}, 32'd0);
    check_id("flush", 5'd0, 1'b0);
    check_eq("flush_pending", hzd_bus.hzd_pending_out, 32'h200);

    // Load to x0 is ignored; ra=0 never stalls.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    check_eq("ld0_pending", hzd_bus.hzd_pending_out, 32'h200);
    check_id("ld0", 5'd0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("ra0_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd0);

    // Same-cycle set and clear of x7: set wins.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    tick();
    check_eq("setclr7_pending", hzd_bus.hzd_pending_out, 32'h280);

    // Writeback of a non-pending register; no instruction -> bubble.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    check_eq("wb3_pending", hzd_bus.hzd_pending_out, 32'h280);
    check_id("noinst", 5'd0, 1'b0);

    // Accepted instruction that does not write rd -> bubble.
    drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    check_id("nowe", 5'd0, 1'b0);

    // Reset in the middle of a stall on x7.
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("use7_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd1);
    tick();
    check_eq("use7_state", {31'd0, hzd_bus.hzd_state_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd0);
    check_eq("rst_mid_pending", hzd_bus.hzd_pending_out, 32'd0);
    check_eq("rst_mid_state", {31'd0, hzd_bus.hzd_state_out}, 32'd0);
    check_id("rst_mid", 5'd0, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_stall", {31'd0, hzd_bus.hzd_stall_out}, 32'd0);
    check_eq("post_rst_state", {31'd0, hzd_bus.hzd_state_out}, 32'd0);

`ifdef HZD_STALL_COUNTER_EN
    check_eq("cnt_reset", {16'd0, stall_count}, 32'd0);
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("cnt_three", {16'd0, stall_count}, 32'd3);
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check_eq("cnt_sat", {16'd0, stall_count}, 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clock_in  input  1  single clock; all state updates on its rising edge.
REQ-002 reset_in  input  1  asynchronous, active-low reset.
REQ-003 hzd_if_valid_in  input  1  IF-stage instruction present.
REQ-004 hzd_if_ra_addr_in  input  5  IF source register A.
REQ-005 hzd_if_rb_addr_in  input  5  IF source register B.
REQ-006 hzd_if_rd_addr_in  input  5  IF destination register.
REQ-007 hzd_if_rd_we_in  input  1  IF instruction writes rd.
REQ-008 hzd_if_load_in  input  1  IF instruction is a load (long latency).
REQ-009 hzd_wb_valid_in  input  1  load data returning this cycle.
REQ-010 hzd_wb_rd_addr_in  input  5  register being written by the returning load.
REQ-011 hzd_flush_in  input  1  pipeline flush request.
REQ-012 hzd_id_rd_addr_out  output  5  ID-stage destination; feeds the forwarding unit rd input.
REQ-013 hzd_id_rd_we_out  output  1  ID-stage destination valid.
REQ-014 hzd_stall_out  output  1  hold IF, insert bubble into ID.
REQ-015 hzd_pending_out  output  32  pending-load bitmap, bit n = register xn.
REQ-016 hzd_state_out  output  1  FSM state, 0=RUN, 1=STALL.

Function
REQ-017 IF instruction is "accepted" when hzd_if_valid_in=1, hzd_stall_out=0 and hzd_flush_in=0.
REQ-018 hzd_stall_out is combinational: valid, no flush, and (ra!=0 and pending[ra] and not (wb_valid and wb_rd==ra)), or the same condition for rb.
REQ-019 ID register: accepted with rd_we=1 and rd!=0 -> captures rd and we=1 next cycle; any other case -> captures rd=0, we=0 (bubble).
REQ-020 Pending set: accepted with load=1, rd_we=1 and rd!=0 -> pending[rd] becomes 1 next cycle.
REQ-021 Pending clear: wb_valid=1 -> pending[wb_rd] becomes 0 next cycle.
REQ-022 Simultaneous set and clear of the same register -> set wins, because the newer load owns it.
REQ-023 pending[0] is constant 0; writes to x0 are ignored.
REQ-024 Flush does not clear pending bits, because in-flight loads still write back; flush only bubbles ID.
REQ-025 FSM RUN->STALL when hzd_stall_out=1.
REQ-026 FSM STALL->RUN when hzd_stall_out=0.
REQ-027 FSM in any state -> RUN when flush=1.
REQ-028 Latency: the stall decision uses same-cycle inputs; the ID register and pending bitmap update one cycle later.
REQ-029 wb_valid for a register that is not pending is harmless; the bit stays 0.

Reset
REQ-030 While reset_in=0, asynchronously drive hzd_id_rd_addr_out=0, hzd_id_rd_we_out=0, hzd_pending_out=0 and hzd_state_out=RUN.
REQ-031 Reset asserted mid-stall drops any pending dependency, so hzd_stall_out=0 while reset_in=0 and after release.
REQ-032 Release of reset is synchronous to clock_in; the first update occurs on the first rising edge after release.

Configuration
REQ-033 Macro HZD_STALL_COUNTER_EN defined -> add output hzd_stall_count_out (16 bits) and a saturating counter of cycles with hzd_stall_out=1.
REQ-034 With HZD_STALL_COUNTER_EN, reset clears the counter to 0 and the counter holds at 16'hFFFF.
REQ-035 Macro HZD_STALL_COUNTER_EN undefined -> the port and counter are absent; all other behaviour is identical.

Verification
REQ-036 Load x5 accepted, next cycle ra=5 -> stall=1, pending=32'h20, ID bubble (rd=0, we=0).
REQ-037 Stalled on x5, then wb_valid with wb_rd=5 in the same cycle -> stall=0 that cycle, instruction accepted, pending[5]=0 next cycle.
REQ-038 Load to rd=0 accepted -> pending stays 0, no stall on ra=0.
REQ-039 Same-cycle load-accept rd=7 and wb rd=7 -> pending[7]=1 next cycle.
REQ-040 Flush while stalled -> state=RUN and ID bubble next cycle, pending bits retained.
REQ-041 Reset mid-stall -> all outputs 0 immediately; with HZD_STALL_COUNTER_EN, 3 stall cycles give count=3 and the count saturates at 16'hFFFF.
